// File: rtl/itrx_amba2_ahb_arbiter.sv
// AMBA2 AHB bus arbiter: fixed-priority or round-robin grant with burst/lock hold
// and SPLIT masking; all bus-facing outputs are registers.
module itrx_amba2_ahb_arbiter #(
  parameter int NM         = 16,
  parameter int NS         = 16,
  parameter int ARB_MODE   = 0,
  parameter int DEF_MASTER = 0,
  parameter int MW         = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic [NM-1:0]      hbusreq,
  input  logic [NM-1:0]      hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  input  logic [1:0]         hresp,
  input  logic [NS*NM-1:0]   hsplit,
  output logic [NM-1:0]      hgrant,
  output logic [MW-1:0]      hmaster,
  output logic               hmastlock
);

  localparam logic [MW-1:0] DEF_IDX = MW'(DEF_MASTER);

  logic [NM-1:0]   split_mask_r;
  logic [3:0]      bcnt_r;
  logic [MW-1:0]   rr_ptr_r;

  logic [3:0]      bcnt_next_s;
  logic [MW-1:0]   gidx_s;
  logic [NM-1:0]   split_clr_s;
  logic [NM-1:0]   split_set_s;
  logic [NM-1:0]   split_next_s;
  logic [NM-1:0]   elig_s;
  logic [MW:0]     rot_s;
  logic [2*NM-1:0] dbl_s;
  logic [NM-1:0]   search_s;
  logic [MW:0]     base_s;
  logic [MW-1:0]   win_idx_s;
  logic            win_valid_s;
  logic            hold_lock_s;
  logic            permit_s;

  function automatic logic [NM-1:0] onehot(input logic [MW-1:0] idx);
    logic [NM-1:0] r;
    r      = {NM{1'b0}};
    r[idx] = 1'b1;
    return r;
  endfunction

  // Map an offset into the rotated search window back to an absolute master index.
  function automatic logic [MW-1:0] wrap_idx(input logic [MW:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= NM) ? MW'(sum - NM) : MW'(sum);
  endfunction

  // Remaining beats of the current owner's burst after this edge.
  always_comb begin
    bcnt_next_s = bcnt_r;
    if (hresp != 2'd0) begin
      bcnt_next_s = 4'd0;
    end else begin
      case (htrans)
        2'd2: begin
          case (hburst)
            3'd2, 3'd3: bcnt_next_s = 4'd3;
            3'd4, 3'd5: bcnt_next_s = 4'd7;
            3'd6, 3'd7: bcnt_next_s = 4'd15;
            default:    bcnt_next_s = 4'd0;
          endcase
        end
        2'd3:    bcnt_next_s = (bcnt_r != 4'd0) ? (bcnt_r - 4'd1) : 4'd0;
        default: bcnt_next_s = bcnt_r;
      endcase
    end
  end

  // Index of the currently granted master.
  always_comb begin
    gidx_s = DEF_IDX;
    for (int i = 0; i < NM; i++) begin
      gidx_s = hgrant[i] ? MW'(i) : gidx_s;
    end
  end

  // Any slave may release a split master.
  always_comb begin
    split_clr_s = {NM{1'b0}};
    for (int s = 0; s < NS; s++) begin
      split_clr_s = split_clr_s | hsplit[s*NM +: NM];
    end
  end

  assign split_set_s  = (hready && (hresp == 2'd3) && (hmaster != DEF_IDX)) ? onehot(hmaster)
                                                                              : {NM{1'b0}};
  assign split_next_s = (split_mask_r | split_set_s) & ~split_clr_s;

  // Round robin rotates the request vector so the slot after the last winner is bit 0.
  assign elig_s   = hbusreq & ~split_mask_r;
  assign rot_s    = {1'b0, rr_ptr_r} + {{MW{1'b0}}, 1'b1};
  assign dbl_s    = {elig_s, elig_s} >> rot_s;
  assign search_s = (ARB_MODE == 1) ? dbl_s[NM-1:0] : elig_s;
  assign base_s   = (ARB_MODE == 1) ? rot_s : {(MW+1){1'b0}};

  // Lowest set bit of the search window wins.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = DEF_IDX;
    for (int j = NM-1; j >= 0; j--) begin
      win_valid_s = win_valid_s | search_s[j];
      win_idx_s   = search_s[j] ? wrap_idx(base_s, j) : win_idx_s;
    end
  end

  assign hold_lock_s = hlock[gidx_s] & hbusreq[gidx_s];
  assign permit_s    = (bcnt_next_s <= 4'd1) && !hold_lock_s;

  // Arbitration state and registered bus outputs.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant       <= onehot(DEF_IDX);
      hmaster      <= DEF_IDX;
      hmastlock    <= 1'b0;
      split_mask_r <= {NM{1'b0}};
      bcnt_r       <= 4'd0;
      rr_ptr_r     <= DEF_IDX;
    end else begin
      split_mask_r <= split_next_s;
      if (hready) begin
        bcnt_r    <= bcnt_next_s;
        hmaster   <= gidx_s;
        hmastlock <= hlock[gidx_s];
        if (permit_s) begin
          hgrant <= onehot(win_idx_s);
          if (win_valid_s) begin
            rr_ptr_r <= win_idx_s;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_itrx_amba2_ahb_arbiter.sv
// Directed + random bench for the AHB arbiter; a fixed-priority and a round-robin
// instance share stimulus and are checked against an integer-level bus model.
module tb_itrx_amba2_ahb_arbiter;
  localparam int NM = 4;
  localparam int NS = 8;
  localparam int MW = 2;
  localparam int DEF = 0;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [NM-1:0]   hbusreq, hlock;
  logic [1:0]      htrans, hresp;
  logic [2:0]      hburst;
  logic            hready;
  logic [NS*NM-1:0] hsplit;
  logic [NM-1:0]   g0, g1;
  logic [MW-1:0]   m0, m1;
  logic            l0, l1;

  int checks = 0;
  int errors = 0;

  // Model state per instance (index 0 = fixed priority, 1 = round robin).
  int            mg[2], mm[2], ml[2], mbc[2], mptr[2];
  logic [NM-1:0] mmask[2];

  always #5 hclk = ~hclk;

  itrx_amba2_ahb_arbiter #(.NM(NM), .NS(NS), .ARB_MODE(0), .DEF_MASTER(DEF)) dut0 (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hresp(hresp), .hsplit(hsplit),
    .hgrant(g0), .hmaster(m0), .hmastlock(l0));

  itrx_amba2_ahb_arbiter #(.NM(NM), .NS(NS), .ARB_MODE(1), .DEF_MASTER(DEF)) dut1 (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hresp(hresp), .hsplit(hsplit),
    .hgrant(g1), .hmaster(m1), .hmastlock(l1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int ng, nmst, nl, nbc, nptr, c;
      bit found;
      logic [NM-1:0] nmask, clr, elig;
      if (hreset) begin
        mg[m] = DEF; mm[m] = DEF; ml[m] = 0; mbc[m] = 0; mptr[m] = DEF; mmask[m] = '0;
      end else begin
        ng = mg[m]; nmst = mm[m]; nl = ml[m]; nbc = mbc[m]; nptr = mptr[m]; nmask = mmask[m];
        clr = '0;
        for (int s = 0; s < NS; s++) clr = clr | hsplit[s*NM +: NM];
        if (hready) begin
          if (hresp != 2'd0)       nbc = 0;
          else if (htrans == 2'd2) nbc = burst_len(hburst) - 1;
          else if (htrans == 2'd3) nbc = (mbc[m] > 0) ? mbc[m] - 1 : 0;
          if (hresp == 2'd3 && mm[m] != DEF) nmask[mm[m]] = 1'b1;
          nmst = mg[m];
          nl   = int'(hlock[mg[m]]);
          if (nbc <= 1 && !(hlock[mg[m]] && hbusreq[mg[m]])) begin
            elig  = hbusreq & ~mmask[m];
            ng    = DEF;
            found = 0;
            for (int k = 0; k < NM; k++) begin
              c = (m == 0) ? k : (mptr[m] + 1 + k) % NM;
              if (!found && elig[c]) begin found = 1; ng = c; end
            end
            if (found && m == 1) nptr = ng;
          end
        end
        nmask = nmask & ~clr;
        mg[m] = ng; mm[m] = nmst; ml[m] = nl; mbc[m] = nbc; mptr[m] = nptr; mmask[m] = nmask;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge hclk);
    @(negedge hclk);
    chk("m_grant0", 32'(g0), 32'(1) << mg[0]);
    chk("m_master0", 32'(m0), 32'(mm[0]));
    chk("m_lock0", 32'(l0), 32'(ml[0]));
    chk("m_grant1", 32'(g1), 32'(1) << mg[1]);
    chk("m_master1", 32'(m1), 32'(mm[1]));
    chk("m_lock1", 32'(l1), 32'(ml[1]));
  endtask

  task automatic drive(input logic [NM-1:0] req, input logic [NM-1:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic [1:0] rs,
                       input logic [NS*NM-1:0] sp);
    hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy; hresp = rs; hsplit = sp;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("rst_grant0", 32'(g0), 32'h1);
    chk("rst_master0", 32'(m0), 32'h0);
    chk("rst_lock0", 32'(l0), 32'h0);
    chk("rst_grant1", 32'(g1), 32'h1);
    hreset = 1'b0;
  endtask

  // INCR4 by master 2 while master 1 waits, optionally with a wait state before each beat.
  task automatic incr4_run(input bit ws);
    do_reset();
    drive(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    step();
    chk("i4_owner", 32'(m0), 32'd2);
    for (int b = 0; b < 4; b++) begin
      if (ws) begin
        drive(4'b0110, 4'b0000, (b == 0) ? 2'd2 : 2'd3, 3'd3, 1'b0, 2'd0, 32'd0);
        step();
      end
      drive(4'b0110, 4'b0000, (b == 0) ? 2'd2 : 2'd3, 3'd3, 1'b1, 2'd0, 32'd0);
      step();
      if (b < 2) begin
        chk("i4_hold0", 32'(g0), 32'b0100);
        chk("i4_hold1", 32'(g1), 32'b0100);
      end else if (b == 2) begin
        chk("i4_move0", 32'(g0), 32'b0010);
        chk("i4_move1", 32'(g1), 32'b0010);
      end else begin
        chk("i4_hmaster", 32'(m0), 32'd1);
      end
    end
  endtask

  initial begin
    hreset = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    for (int m = 0; m < 2; m++) begin
      mg[m] = DEF; mm[m] = DEF; ml[m] = 0; mbc[m] = 0; mptr[m] = DEF; mmask[m] = '0;
    end

    // Fixed priority basics.
    do_reset();
    drive(4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("fp_grant", 32'(g0), 32'b0010);
    step();
    chk("fp_master", 32'(m0), 32'd1);
    drive(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("fp_grant3", 32'(g0), 32'b1000);

    // Round robin rotation with SINGLE transfers.
    do_reset();
    drive(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("rr_grant", 32'(g1), 32'(1) << (k % 4));
      chk("rr_master", 32'(m1), 32'((k - 1) % 4));
    end

    incr4_run(1'b0);
    incr4_run(1'b1);

    // Locked SINGLEs by master 3.
    do_reset();
    drive(4'b1000, 4'b1000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    step();
    chk("lk_master", 32'(m0), 32'd3);
    chk("lk_mastlock", 32'(l0), 32'd1);
    drive(4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1, 2'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("lk_hold", 32'(g0), 32'b1000);
      chk("lk_ml", 32'(l0), 32'd1);
    end
    drive(4'b1001, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("lk_release", 32'(g0), 32'b0001);

    // SPLIT masking and release by slave 5.
    do_reset();
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    step();
    drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b0, 2'd3, 32'd0);
    step();
    drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd3, 32'd0);
    step();
    chk("sp_oldmask0", 32'(g0), 32'b0010);
    chk("sp_rr1", 32'(g1), 32'b0100);
    drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("sp_masked0", 32'(g0), 32'b0100);
    drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd1 << (5*NM + 1));
    step();
    drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("sp_regrant0", 32'(g0), 32'b0010);
    step();
    chk("sp_owner", 32'(m0), 32'd1);
    drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd3, 32'd1 << (5*NM + 1));
    step();
    drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("sp_clrwins0", 32'(g0), 32'b0010);

    // Reset in the middle of a locked INCR8.
    do_reset();
    drive(4'b1000, 4'b1000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    step();
    drive(4'b1000, 4'b1000, 2'd2, 3'd5, 1'b1, 2'd0, 32'd0);
    step();
    drive(4'b1000, 4'b1000, 2'd3, 3'd5, 1'b1, 2'd0, 32'd0);
    step();
    hreset = 1'b1;
    step();
    chk("mr_grant0", 32'(g0), 32'h1);
    chk("mr_master0", 32'(m0), 32'h0);
    chk("mr_lock0", 32'(l0), 32'h0);
    chk("mr_grant1", 32'(g1), 32'h1);
    hreset = 1'b0;
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 32'd0);
    step();
    chk("mr_free", 32'(g0), 32'b0010);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      hreset  = ($urandom_range(0, 99) == 0);
      hbusreq = 4'($urandom);
      hlock   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      htrans  = 2'($urandom);
      hburst  = 3'($urandom);
      hready  = ($urandom_range(0, 3) != 0);
      r       = $urandom_range(0, 15);
      hresp   = (r < 12) ? 2'd0 : (r == 12) ? 2'd1 : (r == 13) ? 2'd2 : 2'd3;
      hsplit  = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/itrx_amba2_ahb_arbiter.md
Name: itrx_amba2_ahb_arbiter

Overview:
- Parametrised AMBA2 AHB bus arbiter for NM masters and NS slaves.
- Selectable fixed-priority or round-robin arbitration.
- Holds the grant for fixed-length bursts and locked sequences; masks SPLIT masters until their slave releases them.
- Sits beside the address decoder and drives hgrant, hmaster and hmastlock for the shared AHB bus.

Parameters:
NM, 16, number of masters (2..16)
NS, 16, number of slaves returning hsplit
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
DEF_MASTER, 0, default master index, granted when no eligible request
MW, $clog2(NM), hmaster width (derived; minimum 1)

Ports:
hclk  in  1  bus clock
hreset  in  1  synchronous reset, active-high
hbusreq  in  NM  per-master bus request
hlock  in  NM  per-master lock request
htrans  in  2  current transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
hburst  in  3  current burst type
hready  in  1  bus-wide transfer-accept
hresp  in  2  muxed slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3)
hsplit  in  NS*NM  per-slave split-release vectors, slave s at [s*NM +: NM]
hgrant  out  NM  one-hot grant, registered
hmaster  out  MW  address-phase owner index, registered
hmastlock  out  1  current address phase is locked, registered

Behaviour:
- Reset (hreset=1 at an hclk edge) gives:
  - hgrant = one-hot DEF_MASTER, hmaster = DEF_MASTER, hmastlock = 0;
  - split mask = 0, burst counter bcnt = 0, round-robin pointer = DEF_MASTER.
  - Reset mid-burst or mid-lock abandons all state immediately.
- Accepted edge: an hclk edge with hready=1. Nothing updates when hready=0, except the split-mask clear.
- Burst counter (tracks the hmaster transfer):
  - Accepted NONSEQ with hburst INCR4/WRAP4 (3,2) → bcnt_next = 3; INCR8/WRAP8 (5,4) → 7; INCR16/WRAP16 (7,6) → 15.
  - Accepted SEQ with bcnt>0 → bcnt-1. Accepted IDLE/BUSY → unchanged.
  - SINGLE/INCR → 0.
  - hresp ≠ OKAY on an accepted edge → 0 (early termination).
- Rearbitration is permitted on an accepted edge only when:
  - bcnt_next ≤ 1, and
  - NOT (hlock[granted master] = 1 and that master is still requesting).
- This timing lets the new grant overlap the last beat's address phase.
- Eligible set = hbusreq & ~split_mask.
  - Mode 0: lowest-index eligible master wins.
  - Mode 1: first eligible master searching upward from (last winner+1) mod NM, wrapping; the pointer updates to each new winner.
  - Empty eligible set → DEF_MASTER.
- When rearbitration is not permitted, hgrant holds.
- On every accepted edge:
  - hmaster <= index(hgrant) as it was before the edge.
  - hmastlock <= hlock[index(hgrant)], also taken before the edge.
  - So hmaster lags hgrant by exactly one accepted edge.
- Split mask:
  - Set: hresp = SPLIT on an accepted edge sets mask[hmaster]. It is not set if hmaster = DEF_MASTER; the default master is never masked.
  - Clear: mask[m] clears on any edge, hready regardless, where the OR over all slaves of hsplit[s][m] = 1.
  - Set and clear of the same bit on the same edge: clear wins.
  - A masked master that holds the grant loses it at the next permitted rearbitration.
- RETRY: no masking; normal rearbitration applies.
- hgrant is always exactly one-hot. Outputs are glitch-free registers with no combinational path from input to output.

Test Plan:
- Mode 0, NM=4: hbusreq=4'b1010 from reset, hready=1 → after 1 edge hgrant=4'b0010; after 2 edges hmaster=1. Then hbusreq=4'b1000 → hgrant=4'b1000 next edge.
- Mode 1, NM=4: hbusreq=4'b1111 held, SINGLE transfers, hready=1 → hgrant cycles 0001→0010→0100→1000→0001. hmaster follows one edge later.
- Master 2 issues an INCR4 (NONSEQ+3 SEQ) while master 1 requests → hgrant stays 4'b0100 until the 3rd beat is accepted (bcnt_next=1), then becomes 4'b0010. hmaster=1 after the 4th beat. Repeat with hready=0 wait states inserted → same beat alignment.
- Master 3 with hlock=1 performs two SINGLEs while master 0 requests → grant is held and hmastlock=1 for both. Grant moves to master 0 only after hlock[3] drops.
- Master 1 receives SPLIT (hresp=3 for 2 cycles, hready 0 then 1) → mask[1]=1 and grant moves to the other requester or DEF_MASTER. Slave 5 pulses hsplit bit 1 → mask clears and master 1 is regranted. On a simultaneous SPLIT and hsplit for master 1, the mask stays 0.
- Assert hreset during a locked INCR8 → next edge: hgrant=one-hot DEF_MASTER, hmaster=DEF_MASTER, hmastlock=0, mask=0.
